// File: rtl/axis_packet_accumulator_if.sv
// rtl/axis_packet_accumulator_if.sv - AXI-Stream style handshake bundle for the packet accumulator
interface axis_packet_accumulator_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_accumulator.sv
// rtl/axis_packet_accumulator.sv - reduces each tlast-delimited packet to one signed sum beat
// A programmed number of packets forms one operation; the last sum carries tlast.
module axis_packet_accumulator #(
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int PCKT_WIDTH  = 32,
   parameter bit SATURATE    = 1'b1,
   parameter bit ALLOW_LOCKS = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      operation_start,
   input  logic [PCKT_WIDTH-1:0]     pckt_num,
   input  logic                      lock,
   input  logic                      external_error,
   output logic                      operation_busy,
   output logic                      operation_complete,
   output logic                      operation_error,
   output logic                      transmission,
   axis_packet_accumulator_if.slave  s_axis,
   axis_packet_accumulator_if.master m_axis
);
   typedef enum logic [1:0] {STR, OPE, ERR, END} state_t;

   localparam logic [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [PCKT_WIDTH-1:0] PCKT_ONE = PCKT_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ACC_WIDTH-1:0]  acc_q, out_data_q, sum;
   logic [ACC_WIDTH:0]    sum_wide;
   logic [PCKT_WIDTH-1:0] pkt_cnt_q, pckt_num_q, pkt_cnt_inc;
   logic                  out_valid_q, out_last_q;
   logic                  lock_act, accept, out_hs, all_accepted, start_ok;

   assign lock_act     = ALLOW_LOCKS && lock;
   assign out_hs       = out_valid_q && m_axis.tready;
   assign pkt_cnt_inc  = pkt_cnt_q + PCKT_ONE;
   assign all_accepted = (pkt_cnt_q == pckt_num_q);
   assign start_ok     = (pckt_num != '0);

   // Once every packet of the operation is in, input stays closed until the next start.
   assign s_axis.tready = (state_q == OPE) && !lock_act && !all_accepted &&
                          (!out_valid_q || m_axis.tready);
   assign accept        = s_axis.tvalid && s_axis.tready;

   assign m_axis.tdata  = out_data_q;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tlast  = out_last_q;

   // One guard bit exposes signed overflow of the running sum.
   assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} +
                     {{(ACC_WIDTH+1-DATA_WIDTH){s_axis.tdata[DATA_WIDTH-1]}}, s_axis.tdata};

   always_comb begin
      sum = sum_wide[ACC_WIDTH-1:0];
      if (SATURATE && (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]))
         sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
   end

   always_comb begin
      state_d = state_q;
      if (external_error) begin
         state_d = ERR;
      end else if (!lock_act) begin
         case (state_q)
            STR, END: if (operation_start) state_d = start_ok ? OPE : ERR;
            OPE:      if (all_accepted && (!out_valid_q || m_axis.tready)) state_d = END;
            ERR:      state_d = STR;
            default:  state_d = STR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= STR;
         acc_q              <= '0;
         pkt_cnt_q          <= '0;
         pckt_num_q         <= '0;
         out_data_q         <= '0;
         out_valid_q        <= 1'b0;
         out_last_q         <= 1'b0;
         operation_busy     <= 1'b0;
         operation_complete <= 1'b0;
         operation_error    <= 1'b0;
         transmission       <= 1'b0;
      end else begin
         state_q            <= state_d;
         operation_busy     <= (state_d == OPE);
         operation_complete <= (state_d == END);
         operation_error    <= (state_d == ERR);
         transmission       <= out_hs;
         if (state_d == ERR) begin
            acc_q       <= '0;
            pkt_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end else if ((state_d == OPE) && (state_q != OPE)) begin
            pckt_num_q <= pckt_num;
            acc_q      <= '0;
            pkt_cnt_q  <= '0;
         end else begin
            if (out_hs) begin
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
            // A tlast accepted in the same cycle as a handshake reloads the output register.
            if (accept) begin
               if (s_axis.tlast) begin
                  out_data_q  <= sum;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (pkt_cnt_inc == pckt_num_q);
                  acc_q       <= '0;
                  pkt_cnt_q   <= pkt_cnt_inc;
               end else begin
                  acc_q <= sum;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_axis_packet_accumulator.sv
// tb/tb_axis_packet_accumulator.sv - self-checking bench for axis_packet_accumulator
module tb_axis_packet_accumulator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        operation_start = 1'b0;
   logic [31:0] pckt_num = '0;
   logic        lock = 1'b0;
   logic        external_error = 1'b0;
   logic        busy, complete, error, transmission;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_packet_accumulator_if #(.WIDTH(16)) s0 ();
   axis_packet_accumulator_if #(.WIDTH(32)) m0 ();

   axis_packet_accumulator dut (
      .clk(clk), .rst(rst), .operation_start(operation_start), .pckt_num(pckt_num),
      .lock(lock), .external_error(external_error), .operation_busy(busy),
      .operation_complete(complete), .operation_error(error), .transmission(transmission),
      .s_axis(s0), .m_axis(m0)
   );

   // 16-bit accumulators, saturating and wrapping, driven by one shared stimulus
   logic        v_start = 1'b0;
   logic [31:0] v_pn = 32'd1;
   logic [15:0] v_tdata = '0;
   logic        v_tvalid = 1'b0, v_tlast = 1'b0, v_mready = 1'b0;
   logic        sat_busy, sat_done, sat_err, sat_tx, wrp_busy, wrp_done, wrp_err, wrp_tx;

   axis_packet_accumulator_if #(.WIDTH(16)) sat_s ();
   axis_packet_accumulator_if #(.WIDTH(16)) sat_m ();
   axis_packet_accumulator_if #(.WIDTH(16)) wrp_s ();
   axis_packet_accumulator_if #(.WIDTH(16)) wrp_m ();

   assign sat_s.tdata = v_tdata;  assign sat_s.tvalid = v_tvalid;
   assign sat_s.tlast = v_tlast;  assign sat_m.tready = v_mready;
   assign wrp_s.tdata = v_tdata;  assign wrp_s.tvalid = v_tvalid;
   assign wrp_s.tlast = v_tlast;  assign wrp_m.tready = v_mready;

   axis_packet_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .operation_start(v_start), .pckt_num(v_pn), .lock(1'b0),
      .external_error(1'b0), .operation_busy(sat_busy), .operation_complete(sat_done),
      .operation_error(sat_err), .transmission(sat_tx), .s_axis(sat_s), .m_axis(sat_m)
   );

   axis_packet_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .SATURATE(1'b0)) dut_wrp (
      .clk(clk), .rst(rst), .operation_start(v_start), .pckt_num(v_pn), .lock(1'b0),
      .external_error(1'b0), .operation_busy(wrp_busy), .operation_complete(wrp_done),
      .operation_error(wrp_err), .transmission(wrp_tx), .s_axis(wrp_s), .m_axis(wrp_m)
   );

   typedef struct {
      shortint a;
      shortint b;
      shortint exp_sat;
      shortint exp_wrap;
   } sat_vec_t;

   logic [31:0] got_d[$];
   logic        got_l[$];

   always @(negedge clk) begin
      #3;
      if (m0.tvalid && m0.tready) begin
         got_d.push_back(m0.tdata);
         got_l.push_back(m0.tlast);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start(input logic [31:0] n);
      operation_start = 1'b1;
      pckt_num        = n;
      @(negedge clk);
      operation_start = 1'b0;
   endtask

   task automatic push(input shortint d, input logic l, output int waited);
      waited = 0;
      s0.tdata  = d;
      s0.tvalid = 1'b1;
      s0.tlast  = l;
      #2;
      while (!s0.tready && waited < 50) begin
         @(negedge clk);
         #2;
         waited++;
      end
      if (!s0.tready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: tready stayed 0, required 1");
      end
      @(negedge clk);
      s0.tvalid = 1'b0;
      s0.tlast  = 1'b0;
   endtask

   task automatic wait_complete(input string name);
      int n;
      n = 0;
      while (!complete && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, complete, 1);
   endtask

   task automatic chk_out(input string name, input int k, input longint d, input logic l);
      if (got_d.size() > k) begin
         chk({name, "_data"}, longint'($signed(got_d[k])), d);
         chk({name, "_last"}, got_l[k], l);
      end else begin
         chk({name, "_missing"}, got_d.size(), k + 1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   function automatic longint clamp32(input longint s);
      if (s > 64'sd2147483647) return 64'sd2147483647;
      if (s < -64'sd2147483648) return -64'sd2147483648;
      return s;
   endfunction

   sat_vec_t vecs[5];
   int       w;
   int       np, len, nb, idx, cyc;
   longint   s_ref;
   shortint  v;
   shortint  bd[$];
   logic     bl[$];
   longint   ex[$];

   initial begin
      vecs[0] = '{a: 32767,  b: 1,      exp_sat: 32767,  exp_wrap: -32768};
      vecs[1] = '{a: -32768, b: -1,     exp_sat: -32768, exp_wrap: 32767};
      vecs[2] = '{a: 100,    b: -200,   exp_sat: -100,   exp_wrap: -100};
      vecs[3] = '{a: -20000, b: -20000, exp_sat: -32768, exp_wrap: 25536};
      vecs[4] = '{a: 20000,  b: 20000,  exp_sat: 32767,  exp_wrap: -25536};

      s0.tdata = '0; s0.tvalid = 1'b0; s0.tlast = 1'b0;
      m0.tready = 1'b1;

      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_complete", complete, 0);
      chk("rst_error", error, 0);
      chk("rst_transmission", transmission, 0);
      chk("rst_tvalid", m0.tvalid, 0);
      chk("rst_tlast", m0.tlast, 0);
      chk("rst_tdata", m0.tdata, 0);
      chk("rst_tready", s0.tready, 0);
      rst = 1'b0;
      tick(1);

      // saturation versus wrap on 16-bit accumulators
      for (int i = 0; i < 5; i++) begin
         v_start = 1'b1;
         v_pn    = 32'd1;
         @(negedge clk);
         v_start  = 1'b0;
         v_tdata  = vecs[i].a;
         v_tvalid = 1'b1;
         v_tlast  = 1'b0;
         #2;
         chk("sat_tready", sat_s.tready, 1);
         @(negedge clk);
         v_tdata = vecs[i].b;
         v_tlast = 1'b1;
         @(negedge clk);
         v_tvalid = 1'b0;
         v_tlast  = 1'b0;
         chk("sat_sum", longint'($signed(sat_m.tdata)), vecs[i].exp_sat);
         chk("wrap_sum", longint'($signed(wrp_m.tdata)), vecs[i].exp_wrap);
         chk("sat_tlast", sat_m.tlast, 1);
         v_mready = 1'b1;
         @(negedge clk);
         v_mready = 1'b0;
         chk("sat_complete", sat_done, 1);
      end

      // basic sum: {1,2,3} and {-4,10}
      got_d.delete(); got_l.delete();
      m0.tready = 1'b1;
      start(2);
      chk("basic_busy", busy, 1);
      push(1, 0, w); push(2, 0, w); push(3, 1, w);
      push(-4, 0, w); push(10, 1, w);
      chk("basic_pend_tvalid", m0.tvalid, 1);
      chk("basic_pend_tdata", m0.tdata, 6);
      chk("basic_pend_complete", complete, 0);
      chk("basic_closed_tready", s0.tready, 0);
      tick(1);
      chk("basic_complete", complete, 1);
      chk("basic_transmission", transmission, 1);
      chk("basic_tvalid_low", m0.tvalid, 0);
      chk("basic_count", got_d.size(), 2);
      chk_out("basic0", 0, 6, 0);
      chk_out("basic1", 1, 6, 1);

      // backpressure: {5},{7},{9} with the sink stalled
      got_d.delete(); got_l.delete();
      m0.tready = 1'b0;
      start(3);
      push(5, 1, w);
      s0.tdata = 7; s0.tvalid = 1'b1; s0.tlast = 1'b1;
      repeat (4) begin
         #2;
         chk("bp_tready", s0.tready, 0);
         chk("bp_hold", m0.tdata, 5);
         @(negedge clk);
      end
      m0.tready = 1'b1;
      push(7, 1, w);
      push(9, 1, w);
      s0.tdata = 99; s0.tvalid = 1'b1; s0.tlast = 1'b1;
      #2;
      chk("bp_no_extra_tready", s0.tready, 0);
      s0.tvalid = 1'b0; s0.tlast = 1'b0;
      wait_complete("bp_complete");
      chk("bp_count", got_d.size(), 3);
      chk_out("bp0", 0, 5, 0);
      chk_out("bp1", 1, 7, 0);
      chk_out("bp2", 2, 9, 1);

      // throughput: back-to-back single-beat packets
      got_d.delete(); got_l.delete();
      start(4);
      push(11, 1, w); chk("tp_wait0", w, 0);
      push(-3, 1, w); chk("tp_wait1", w, 0);
      push(0, 1, w);  chk("tp_wait2", w, 0);
      push(7, 1, w);  chk("tp_wait3", w, 0);
      wait_complete("tp_complete");
      chk_out("tp0", 0, 11, 0);
      chk_out("tp1", 1, -3, 0);
      chk_out("tp3", 3, 7, 1);

      // reset with an output beat pending
      m0.tready = 1'b0;
      start(2);
      push(5, 1, w);
      chk("rstmid_pend", m0.tvalid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_tvalid", m0.tvalid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_tdata", m0.tdata, 0);
      m0.tready = 1'b1;

      // zero packets
      start(0);
      chk("zero_error", error, 1);
      chk("zero_busy", busy, 0);
      chk("zero_tready", s0.tready, 0);
      tick(1);
      chk("zero_error_drop", error, 0);
      chk("zero_str_complete", complete, 0);

      // abort mid-packet, then a fresh packet {3,4}
      got_d.delete(); got_l.delete();
      start(1);
      push(1, 0, w); push(2, 0, w);
      external_error = 1'b1;
      @(negedge clk);
      external_error = 1'b0;
      chk("abort_error", error, 1);
      chk("abort_tvalid", m0.tvalid, 0);
      chk("abort_tready", s0.tready, 0);
      tick(1);
      chk("abort_error_drop", error, 0);
      start(1);
      push(3, 0, w); push(4, 1, w);
      wait_complete("abort_complete");
      chk("abort_count", got_d.size(), 1);
      chk_out("abort", 0, 7, 1);

      // lock held mid-packet
      got_d.delete(); got_l.delete();
      start(1);
      push(1, 0, w); push(1, 0, w);
      lock = 1'b1;
      s0.tdata = 1; s0.tvalid = 1'b1; s0.tlast = 1'b0;
      repeat (3) begin
         #2;
         chk("lock_tready", s0.tready, 0);
         chk("lock_busy", busy, 1);
         @(negedge clk);
      end
      lock = 1'b0;
      push(1, 0, w); push(1, 1, w);
      wait_complete("lock_complete");
      chk_out("lock", 0, 4, 1);

      // randomized operations against a packet-level model
      do_reset();
      for (int op = 0; op < 16; op++) begin
         bd.delete(); bl.delete(); ex.delete();
         got_d.delete(); got_l.delete();
         np = $urandom_range(1, 5);
         for (int p = 0; p < np; p++) begin
            len   = $urandom_range(1, 4);
            s_ref = 0;
            for (int b = 0; b < len; b++) begin
               v = shortint'($urandom_range(0, 65535));
               bd.push_back(v);
               bl.push_back(b == len - 1);
               s_ref = clamp32(s_ref + longint'(v));
            end
            ex.push_back(s_ref);
         end
         nb = bd.size();
         m0.tready = 1'b1;
         start(np);
         idx = 0;
         cyc = 0;
         while ((idx < nb || !complete) && cyc < 3000) begin
            if (idx < nb) begin
               s0.tvalid = ($urandom_range(3) != 0);
               s0.tdata  = bd[idx];
               s0.tlast  = bl[idx];
            end else begin
               s0.tvalid = 1'b0;
               s0.tlast  = 1'b0;
            end
            m0.tready = ($urandom_range(9) < 7);
            lock      = ($urandom_range(9) == 0);
            #2;
            if (s0.tvalid && s0.tready) idx++;
            @(negedge clk);
            cyc++;
         end
         s0.tvalid = 1'b0; s0.tlast = 1'b0; lock = 1'b0; m0.tready = 1'b1;
         chk("rand_timeout", cyc < 3000, 1);
         chk("rand_count", got_d.size(), ex.size());
         for (int k = 0; k < ex.size(); k++)
            chk_out("rand", k, ex[k], k == ex.size() - 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axis_packet_accumulator.md
# axis_packet_accumulator

Downstream consumer of the AXI-Stream packet splitter: each tlast-delimited input packet is reduced to one signed sum, emitted as a single output beat. After a programmed number of packets the output beat carries tlast and the operation completes. Control and interrupt signalling matches the splitter's, so both stages can be sequenced by the same controller.

## Interface
- DATA_WIDTH, 16: input word width; words are two's-complement signed.
- ACC_WIDTH, 32: accumulator and output data width; must be ≥ DATA_WIDTH.
- PCKT_WIDTH, 32: width of the packet-count field.
- SATURATE, 1: 1 = clamp at signed max/min; 0 = two's-complement wrap.
- ALLOW_LOCKS, 1: 1 = `lock` freezes the FSM; 0 = `lock` ignored.
- clk  in  1  clock. Single clock domain: one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- operation_start  in  1  start request, sampled in STR/END.
- pckt_num  in  PCKT_WIDTH  packets per operation; latched on start.
- lock  in  1  freeze FSM and stall input (when ALLOW_LOCKS).
- external_error  in  1  forces ERR.
- operation_busy  out  1  high while in OPE.
- operation_complete  out  1  high while in END.
- operation_error  out  1  high while in ERR.
- transmission  out  1  registered: m_axis handshake occurred in the previous cycle.
- s_axis_tdata  in  DATA_WIDTH  input word.
- s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tlast  in  1: packet delimiter.
- m_axis_tdata  out  ACC_WIDTH  packet sum.
- m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1: high on the last packet's sum.

## Operation
- FSM states: STR, OPE, ERR, END. Next-state logic priority: rst > external_error > lock > normal transitions.
- STR: accumulator and packet counter held at 0.
  - operation_start=1 with pckt_num≠0 → OPE; pckt_num latched.
  - operation_start=1 with pckt_num=0 → ERR.
- OPE accept condition: s_axis_tready = busy && !(ALLOW_LOCKS && lock) && (!m_axis_tvalid || m_axis_tready).
- On each accepted beat:
  - sum = acc + sign-extend(tdata), saturated or wrapped according to SATURATE.
  - Not tlast: acc ← sum.
  - tlast: output register ← sum; m_axis_tvalid ← 1; m_axis_tlast ← (pkt_cnt == pckt_num−1); acc ← 0; pkt_cnt ← pkt_cnt+1.
- Output register holds its data until the handshake completes.
- A handshake on the final packet's beat (m_axis_tlast=1) → END.
- After the final tlast beat is accepted, s_axis_tready stays 0. The block never accepts input beyond pckt_num packets.
- END: operation_start → OPE (new pckt_num latched); otherwise stay in END.
- ERR: lasts one cycle, then → STR. On entering ERR: accumulator cleared, pkt_cnt cleared, m_axis_tvalid dropped.
- lock (with ALLOW_LOCKS=1): FSM holds its state and s_axis_tready=0. A pending output beat may still complete its handshake, but the END transition waits until lock is released.

## Timing
- Reset: operation_busy, operation_complete, operation_error, transmission, m_axis_tvalid, m_axis_tlast, m_axis_tdata are all 0. FSM = STR, accumulator = 0.
- Status outputs are registered from the next-state value, so they change in the same cycle as the state register.
- operation_start sampled at edge N → operation_busy=1 and s_axis_tready eligible from N+1.
- Latency: tlast beat accepted at edge N → m_axis_tvalid=1 from N+1.
- Throughput: one beat/cycle sustained when m_axis_tready=1, including back-to-back single-beat packets.
- Simultaneous output handshake and new tlast acceptance in the same cycle: the output register reloads and m_axis_tvalid stays 1.
- transmission asserted at N+1 for a handshake at edge N.
- rst mid-operation: next cycle is STR with reset output values. A pending output beat is discarded.
- external_error mid-packet: ERR on the next edge, partial sum discarded, then STR.

## Test plan
- Basic sum, pckt_num=2: packets {1,2,3} and {−4,10} → outputs 6 (tlast=0) then 6 (tlast=1); operation_complete rises the cycle after the second handshake.
- Backpressure: pckt_num=3 single-beat packets {5},{7},{9} with m_axis_tready=0 for 4 cycles → s_axis_tready=0 while the output is held; outputs 5, 7, 9 in order, none lost.
- Saturation: SATURATE=1, ACC_WIDTH=16, DATA_WIDTH=16, packet {32767,1} → 32767. With SATURATE=0 → −32768.
- Zero packets: start with pckt_num=0 → operation_error high one cycle, then STR; no s_axis_tready.
- Abort: external_error asserted after 2 beats of a 4-beat packet → ERR then STR, m_axis_tvalid=0. A new start with packet {3,4} → 7.
- Lock: lock held 3 cycles mid-packet → s_axis_tready=0 and state unchanged. After release the packet {1,1,1,1} completes → 4.
